instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the CPU datapath/control unit: owns the PC, issues in-order
//  requests to instruction memory, buffers returned words, presents {instr, pc} to the datapath
//  over valid/ready. Datapath redirects the PC on taken branch/jump; stale in-flight words are dropped.
// PARAMETERS
//  PC_W        16      PC / imem address width (byte address)
//  INSTR_W     16      instruction width
//  RESET_PC    16'h0   PC loaded at reset
//  BUF_DEPTH   2       instruction buffer entries (power of 2, >=2); also max in-flight credit
// PORTS
//  clk            in   1        single clock, rising edge
//  rst            in   1        asynchronous, active-high reset
//  imem_req       out  1        request valid; imem accepts every cycle it is high
//  imem_addr      out  PC_W     request address (always even)
//  imem_rvalid    in   1        response valid; responses in request order, latency >=1 cycle
//  imem_rdata     in   INSTR_W  response word
//  instr_valid    out  1        buffer head valid
//  instr          out  INSTR_W  buffer head instruction
//  instr_pc       out  PC_W     address of buffer head
//  instr_ready    in   1        datapath consumes head when valid&ready
//  redirect_valid in   1        taken branch/jump, one-cycle pulse
//  redirect_pc    in   PC_W     new fetch address (bit 0 ignored, forced 0)
// BEHAVIOUR
//  Reset (async assert): pc=RESET_PC, state=BOOT, buffer empty, outstanding=0, drop_cnt=0;
//   imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
//  FSM: BOOT -> RUN after one cycle (no request in BOOT).
//   RUN: imem_req=1 iff outstanding+buf_count < BUF_DEPTH and no redirect this cycle;
//        on issue pc<=pc+2 (wraps 16'hFFFE -> 16'h0000), outstanding++.
//   RUN + redirect: flush buffer, pc<=redirect_pc, drop_cnt<=outstanding (minus any response
//        this cycle); go DRAIN if that is nonzero, else stay RUN.
//   DRAIN: no requests; each imem_rvalid decrements drop_cnt and is discarded; ->RUN when 0.
//        Redirect in DRAIN only reloads pc.
//  Response accepted (drop_cnt==0): written to buffer tail with its pc; outstanding--.
//  Latency: rvalid in cycle N -> instr_valid in N+1 (registered buffer, no bypass).
//  Handshake: instr/instr_pc stable while instr_valid & !instr_ready. Push and pop in same
//   cycle allowed when full (credit scheme guarantees no overflow); overflow is an assertion.
//  Simultaneous redirect + pop: pop completes, buffer then flushed. Redirect + rvalid same
//   cycle: that response is stale and dropped.
//  Reset mid-operation: all state cleared immediately; late imem responses after reset are
//   the memory's responsibility (imem shares rst).
// CONFIGURATION
//  IFU_PERF_EN defined: adds out perf_fetched[31:0] (handshakes completed) and
//   perf_dropped[15:0] (stale responses discarded); both saturate, reset to 0.
//  Not defined: ports and counters absent; no other behaviour changes.
// STRUCTURE
//  Shared cpu_pkg: pc_t, instr_t, PC_STEP=2, ifu_state_e {BOOT,RUN,DRAIN}.
//  Sub-module ifu_buf: BUF_DEPTH-entry FIFO of {pc,instr} with push/pop/flush/count.
// TESTING
//  1 reset release, imem 1-cycle latency, ready=1 -> first req addr 0x0000 in cycle 2,
//    then 0x0002,0x0004..; instr_valid every cycle after fill, instr_pc matches.
//  2 ready=0 for 6 cycles -> exactly BUF_DEPTH requests issued, head held stable, none lost.
//  3 redirect to 0x0040 with 2 in flight -> both dropped, DRAIN 2 cycles, next instr_pc=0x0040.
//  4 redirect same cycle as pop and rvalid -> popped word delivered once, rvalid word dropped.
//  5 redirect_pc=0xFFFE -> instr_pc sequence 0xFFFE, 0x0000, 0x0002.
//  6 rst asserted mid-DRAIN -> outputs zero same cycle, restart fetch at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: PC/instruction types, the PC increment and fetch FSM states.
package cpu_pkg;
  localparam int CPU_PC_W    = 16;
  localparam int CPU_INSTR_W = 16;
  localparam int PC_STEP     = 2;

  typedef logic [CPU_PC_W-1:0]    pc_t;
  typedef logic [CPU_INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } ifu_state_e;
endpackage

// File: rtl/ifu_buf.sv
// Small power-of-two FIFO of {pc, instr} pairs feeding the datapath; flush empties it in one cycle.
module ifu_buf #(
  parameter int DEPTH   = 2,
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [PC_W-1:0]          pushPc,
  input  logic [INSTR_W-1:0]       pushInstr,
  output logic [PC_W-1:0]          headPc,
  output logic [INSTR_W-1:0]       headInstr,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]    pcMem    [DEPTH];
  logic [INSTR_W-1:0] instrMem [DEPTH];
  logic [AW-1:0]      rdPtr, wrPtr;
  logic               doPop;

  assign doPop = pop && (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push)  wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(push) - CW'(doPop);
    end
  end

  // Payload storage is unreset; the parent qualifies the head with count.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pcMem[wrPtr]    <= pushPc;
      instrMem[wrPtr] <= pushInstr;
    end
  end

  assign headPc    = pcMem[rdPtr];
  assign headInstr = instrMem[rdPtr];

  noOverflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !doPop && count == CW'(DEPTH)));
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests under a credit limit and buffers words.
// Optional build macro IFU_PERF_EN adds saturating perf_fetched / perf_dropped counters.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              INSTR_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [15:0]        perf_dropped
`endif
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  ifu_state_e         state, stateNxt;
  logic [PC_W-1:0]    pc, respPc, redirectTgt;
  logic [CW-1:0]      outstanding, outstandingNxt, dropCnt, dropCntNxt, bufCount;
  logic [CW:0]        creditUsed;
  logic               push, pop;
  logic [PC_W-1:0]    headPc;
  logic [INSTR_W-1:0] headInstr;

  assign redirectTgt = redirect_pc & ~PC_W'(1);
  assign creditUsed  = {1'b0, outstanding} + {1'b0, bufCount};
  assign pop         = instr_valid && instr_ready;
  // A response arriving with a redirect belongs to the old path and is never buffered.
  assign push        = imem_rvalid && (state == RUN) && !redirect_valid;

  always_comb begin
    stateNxt       = state;
    outstandingNxt = outstanding;
    dropCntNxt     = dropCnt;
    imem_req       = 1'b0;
    unique case (state)
      BOOT: stateNxt = RUN;
      RUN: begin
        if (redirect_valid) begin
          outstandingNxt = '0;
          dropCntNxt     = outstanding - CW'(imem_rvalid);
          stateNxt       = (dropCntNxt != '0) ? DRAIN : RUN;
        end else begin
          imem_req       = creditUsed < (CW+1)'(BUF_DEPTH);
          outstandingNxt = outstanding + CW'(imem_req) - CW'(imem_rvalid);
        end
      end
      DRAIN: begin
        if (imem_rvalid) dropCntNxt = dropCnt - 1'b1;
        if (dropCntNxt == '0) stateNxt = RUN;
      end
      default: stateNxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
    end else begin
      state       <= stateNxt;
      outstanding <= outstandingNxt;
      dropCnt     <= dropCntNxt;
      if (redirect_valid) begin
        pc     <= redirectTgt;
        respPc <= redirectTgt;
      end else begin
        if (imem_req) pc     <= pc + PC_W'(PC_STEP);
        if (push)     respPc <= respPc + PC_W'(PC_STEP);
      end
    end
  end

  assign imem_addr = pc;

  ifu_buf #(
    .DEPTH   (BUF_DEPTH),
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) uBuf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .pushPc    (respPc),
    .pushInstr (imem_rdata),
    .headPc    (headPc),
    .headInstr (headInstr),
    .count     (bufCount)
  );

  assign instr_valid = (bufCount != '0);
  assign instr       = instr_valid ? headInstr : '0;
  assign instr_pc    = instr_valid ? headPc    : '0;

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (pop && perf_fetched != '1) perf_fetched <= perf_fetched + 1'b1;
      if (imem_rvalid && !push && perf_dropped != '1) perf_dropped <= perf_dropped + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order imem model with random latency and a queue-level fetch model.
module tb_instr_fetch_unit;
  localparam int PC_W = 16;
  localparam int INSTR_W = 16;
  localparam int DEPTH = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic clk = 1'b0;
  logic rst;
  logic imem_req, imem_rvalid, instr_valid, instr_ready, redirect_valid;
  logic [15:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetched;
  logic [15:0] perf_dropped;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef IFU_PERF_EN
    , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
  );

  typedef struct { logic [15:0] pc; logic [15:0] ins; } word_t;
  typedef struct { logic [15:0] addr; int due; } req_t;

  word_t bq[$];
  req_t  mq[$];
  int stale, cyc, lastDue, latMin, latMax, nChecks, nFails, reqSeen, hsTotal, dropTotal;
  logic [15:0] nextReqPc, hsPc;
  bit boot, hsSeen;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // One clock: check outputs against the model at negedge, advance model, drive memory after posedge.
  task automatic tick();
    req_t r;
    bit expReq, mhs;
    int lat;
    @(negedge clk);
    hsSeen = 0;
    reqSeen = 0;
    if (rst) begin
      nChecks++;
      if (imem_req !== 1'b0 || imem_addr !== RESET_PC || instr_valid !== 1'b0 || instr !== 16'h0 || instr_pc !== 16'h0) begin
        nFails++;
        $display("FAIL reset_outputs: req=%b addr=%h valid=%b instr=%h pc=%h, want 0/%h/0/0000/0000", imem_req, imem_addr, instr_valid, instr, instr_pc, RESET_PC);
      end
    end else begin
      nChecks++;
      if (instr_valid !== (bq.size() != 0)) begin
        nFails++;
        $display("FAIL instr_valid: got %b want %b (cycle %0d)", instr_valid, bq.size() != 0, cyc);
      end
      if (bq.size() != 0) begin
        nChecks++;
        if (instr !== bq[0].ins || instr_pc !== bq[0].pc) begin
          nFails++;
          $display("FAIL head: got pc=%h instr=%h want pc=%h instr=%h (cycle %0d)", instr_pc, instr, bq[0].pc, bq[0].ins, cyc);
        end
      end
      expReq = !boot && stale == 0 && !redirect_valid && (mq.size() + bq.size() < DEPTH);
      nChecks++;
      if (imem_req !== expReq) begin
        nFails++;
        $display("FAIL imem_req: got %b want %b (cycle %0d)", imem_req, expReq, cyc);
      end
      if (imem_req === 1'b1) begin
        reqSeen = 1;
        nChecks++;
        if (imem_addr !== nextReqPc) begin
          nFails++;
          $display("FAIL imem_addr: got %h want %h (cycle %0d)", imem_addr, nextReqPc, cyc);
        end
      end
      if (instr_valid === 1'b1 && instr_ready) begin
        hsSeen = 1;
        hsPc = instr_pc;
      end
      mhs = (bq.size() != 0) && instr_ready;
      if (mhs) begin
        void'(bq.pop_front());
        hsTotal++;
      end
      if (imem_rvalid && mq.size() != 0) begin
        r = mq.pop_front();
        if (redirect_valid || stale > 0) begin
          dropTotal++;
          if (!redirect_valid) stale--;
        end else begin
          bq.push_back('{r.addr, memWord(r.addr)});
        end
      end
      if (redirect_valid) begin
        bq.delete();
        stale = mq.size();
        nextReqPc = redirect_pc & 16'hFFFE;
      end else if (imem_req === 1'b1) begin
        lat = $urandom_range(latMax, latMin);
        lastDue = (cyc + lat > lastDue + 1) ? cyc + lat : lastDue + 1;
        mq.push_back('{nextReqPc, lastDue});
        nextReqPc = nextReqPc + 16'd2;
      end
      nChecks++;
      if (bq.size() > DEPTH) begin
        nFails++;
        $display("FAIL occupancy: model buffer holds %0d, limit %0d", bq.size(), DEPTH);
      end
      boot = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    if (!rst && mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata = memWord(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata = 16'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    bq.delete();
    mq.delete();
    stale = 0;
    lastDue = 0;
    hsTotal = 0;
    dropTotal = 0;
    nextReqPc = RESET_PC;
    tick();
    tick();
    rst = 1'b0;
    boot = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_rvalid = 1'b0;
    #1;
    nChecks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC || instr_valid !== 1'b0 || instr !== 16'h0 || instr_pc !== 16'h0) begin
      nFails++;
      $display("FAIL reset_state: req=%b addr=%h valid=%b instr=%h pc=%h", imem_req, imem_addr, instr_valid, instr, instr_pc);
    end
    latMin = 1; latMax = 1; instr_ready = 1'b1;
    do_reset();
    tick();
    nChecks++;
    if (reqSeen != 0) begin nFails++; $display("FAIL boot_request: got %0d want 0", reqSeen); end
    tick();
    nChecks++;
    if (reqSeen != 1) begin nFails++; $display("FAIL first_request_cycle2: got %0d want 1", reqSeen); end
  endtask

  task automatic test_sequential();
    logic [15:0] expPc;
    int hs;
    latMin = 1; latMax = 1; instr_ready = 1'b1;
    do_reset();
    expPc = RESET_PC;
    hs = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (hsSeen) begin
        nChecks++;
        if (hsPc !== expPc) begin nFails++; $display("FAIL seq_pc: got %h want %h", hsPc, expPc); end
        expPc = expPc + 16'd2;
        hs++;
      end
    end
    nChecks++;
    if (hs < 10) begin nFails++; $display("FAIL seq_throughput: got %0d handshakes want >=10", hs); end
  endtask

  task automatic test_stall();
    int reqs, hs;
    logic [15:0] expPc;
    latMin = 1; latMax = 1; instr_ready = 1'b0;
    do_reset();
    reqs = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      reqs += reqSeen;
      if (i >= 4) begin
        nChecks++;
        if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instr !== memWord(RESET_PC)) begin
          nFails++;
          $display("FAIL stall_head: valid=%b pc=%h instr=%h want 1/%h/%h", instr_valid, instr_pc, instr, RESET_PC, memWord(RESET_PC));
        end
      end
    end
    nChecks++;
    if (reqs != DEPTH) begin nFails++; $display("FAIL stall_requests: got %0d want %0d", reqs, DEPTH); end
    instr_ready = 1'b1;
    expPc = RESET_PC;
    hs = 0;
    for (int i = 0; i < 40 && hs < 6; i++) begin
      tick();
      if (hsSeen) begin
        nChecks++;
        if (hsPc !== expPc) begin nFails++; $display("FAIL stall_release_pc: got %h want %h", hsPc, expPc); end
        expPc = expPc + 16'd2;
        hs++;
      end
    end
    nChecks++;
    if (hs != 6) begin nFails++; $display("FAIL stall_release_timeout: got %0d handshakes want 6", hs); end
  endtask

  task automatic test_redirect_drain();
    int quiet, i;
    bit got;
    latMin = 3; latMax = 3; instr_ready = 1'b1;
    do_reset();
    tick(); tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    quiet = 0;
    for (i = 0; i < 10; i++) begin
      tick();
      if (reqSeen) break;
      quiet++;
    end
    nChecks++;
    if (quiet != 2) begin nFails++; $display("FAIL drain_cycles: got %0d want 2", quiet); end
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (hsSeen) begin
        got = 1;
        nChecks++;
        if (hsPc !== 16'h0040) begin nFails++; $display("FAIL drain_next_pc: got %h want 0040", hsPc); end
      end
    end
    if (!got) begin nChecks++; nFails++; $display("FAIL drain_next_timeout: no handshake, want pc 0040"); end
  endtask

  task automatic test_redirect_pop_rvalid();
    logic [15:0] popPc, tgt;
    bit found, got;
    latMin = 1; latMax = 1; instr_ready = 1'b1;
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (instr_valid === 1'b1 && imem_rvalid === 1'b1 && bq.size() != 0) found = 1;
    end
    nChecks++;
    if (!found) begin
      nFails++;
      $display("FAIL pop_rvalid_setup: valid and rvalid never coincided");
    end else begin
      popPc = bq[0].pc;
      tgt = 16'h0100 | (16'($urandom) & 16'h0EFE);
      redirect_valid = 1'b1;
      redirect_pc = tgt;
      tick();
      nChecks++;
      if (!hsSeen || hsPc !== popPc) begin
        nFails++;
        $display("FAIL redirect_pop: handshake=%b pc=%h want 1/%h", hsSeen, hsPc, popPc);
      end
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        tick();
        if (hsSeen) begin
          got = 1;
          nChecks++;
          if (hsPc !== tgt) begin nFails++; $display("FAIL redirect_pop_next: got %h want %h", hsPc, tgt); end
        end
      end
      if (!got) begin nChecks++; nFails++; $display("FAIL redirect_pop_timeout: no handshake after redirect"); end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp3 [3];
    int n;
    exp3[0] = 16'hFFFE; exp3[1] = 16'h0000; exp3[2] = 16'h0002;
    latMin = 1; latMax = 2; instr_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      tick();
      if (hsSeen) begin
        nChecks++;
        if (hsPc !== exp3[n]) begin nFails++; $display("FAIL wrap_pc%0d: got %h want %h", n, hsPc, exp3[n]); end
        n++;
      end
    end
    if (n != 3) begin nChecks++; nFails++; $display("FAIL wrap_timeout: got %0d handshakes want 3", n); end
  endtask

  task automatic test_reset_drain();
    bit got;
    latMin = 4; latMax = 4; instr_ready = 1'b0;
    do_reset();
    tick(); tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0080;
    tick();
    nChecks++;
    if (imem_req !== 1'b0) begin nFails++; $display("FAIL drain_req: got %b want 0", imem_req); end
    rst = 1'b1;
    imem_rvalid = 1'b0;
    #1;
    nChecks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC || instr_valid !== 1'b0 || instr !== 16'h0 || instr_pc !== 16'h0) begin
      nFails++;
      $display("FAIL reset_mid_drain: req=%b addr=%h valid=%b instr=%h pc=%h", imem_req, imem_addr, instr_valid, instr, instr_pc);
    end
    latMin = 1; latMax = 1; instr_ready = 1'b1;
    do_reset();
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (hsSeen) begin
        got = 1;
        nChecks++;
        if (hsPc !== RESET_PC) begin nFails++; $display("FAIL restart_pc: got %h want %h", hsPc, RESET_PC); end
      end
    end
    if (!got) begin nChecks++; nFails++; $display("FAIL restart_timeout: no handshake after reset"); end
  endtask

  task automatic test_random();
    logic [15:0] expNext, tgt;
    int hsCnt;
    bit redir;
    latMin = 1; latMax = 4; instr_ready = 1'b1;
    do_reset();
    expNext = RESET_PC;
    hsCnt = 0;
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(3, 0) != 0);
      redir = (i > 3) && ($urandom_range(15, 0) == 0);
      tgt = 16'($urandom);
      redirect_valid = redir;
      redirect_pc = tgt;
      tick();
      if (hsSeen) begin
        nChecks++;
        if (hsPc !== expNext) begin nFails++; $display("FAIL random_order: got %h want %h (cycle %0d)", hsPc, expNext, cyc); end
        expNext = hsPc + 16'd2;
        hsCnt++;
      end
      if (redir) expNext = tgt & 16'hFFFE;
    end
    nChecks++;
    if (hsCnt < 100) begin nFails++; $display("FAIL random_progress: got %0d handshakes want >=100", hsCnt); end
`ifdef IFU_PERF_EN
    nChecks++;
    if (perf_fetched !== 32'(hsTotal) || perf_dropped !== 16'(dropTotal)) begin
      nFails++;
      $display("FAIL perf_counters: fetched=%0d dropped=%0d want %0d/%0d", perf_fetched, perf_dropped, hsTotal, dropTotal);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = 16'h0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0;
    nChecks = 0; nFails = 0; cyc = 0; boot = 0; stale = 0; lastDue = 0;
    hsTotal = 0; dropTotal = 0; nextReqPc = RESET_PC; hsPc = 16'h0; hsSeen = 0; reqSeen = 0;
    latMin = 1; latMax = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_drain();
    test_redirect_pop_rvalid();
    test_wrap();
    test_reset_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
